// File: rtl/mem_data_access_pkg.sv
// Shared CPU types for the MEM-stage data access unit: load/store descriptors,
// access-size encodings, the access FSM state enum and the alignment rule.
package mem_data_access_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef struct packed {
    logic       ReadMem;
    logic       sign;
    logic [1:0] size;
  } LoadType;

  typedef struct packed {
    logic       DMWr;
    logic [1:0] size;
  } StoreType;

  typedef enum logic [2:0] {
    DACC_IDLE   = 3'd0,
    DACC_REQ    = 3'd1,
    DACC_WAIT   = 3'd2,
    DACC_DONE   = 3'd3,
    DACC_CANCEL = 3'd4
  } DAccState;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SIZE_H:  mis = addr_lo[0];
      SIZE_W:  mis = (addr_lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_data_access_store_lane_gen.sv
// Store lane steering: replicates store data across byte lanes and builds the
// byte-enable mask for the addressed lanes.
module store_lane_gen
  import mem_data_access_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] outb_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o
);

  always_comb begin
    wstrb_o = 4'b1111;
    wdata_o = outb_i;
    case (size_i)
      SIZE_B: begin
        wstrb_o = 4'b0001 << addr_lo_i;
        wdata_o = {4{outb_i[7:0]}};
      end
      SIZE_H: begin
        wstrb_o = 4'b0011 << addr_lo_i;
        wdata_o = {2{outb_i[15:0]}};
      end
      default: begin
        wstrb_o = 4'b1111;
        wdata_o = outb_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_data_access.sv
// MEM-stage data memory access: alignment check, bus request FSM, pipeline
// stall generation and absorption of responses orphaned by a flush.
module mem_data_access
  import mem_data_access_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] MEM_ALUOut,
  input  logic [31:0] MEM_OutB,
  input  LoadType     MEM_LoadType,
  input  StoreType    MEM_StoreType,
  input  logic        MEM_ExceptValid,
  input  logic        MEM_Flush,
  input  logic        MEM_Advance,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic [31:0] MEM_DMOut,
  output logic        MEM_DStall,
  output logic        MEM_AdEL,
  output logic        MEM_AdES
);

  DAccState    state_q;
  logic [31:0] rbuf_q;
  logic        mis_s;
  logic        need_s;
  logic [3:0]  lane_wstrb_s;

  assign data_wr   = MEM_StoreType.DMWr;
  assign data_size = MEM_StoreType.DMWr ? MEM_StoreType.size : MEM_LoadType.size;
  assign data_addr = MEM_ALUOut;

  assign mis_s    = is_misaligned(data_size, MEM_ALUOut[1:0]);
  assign MEM_AdEL = MEM_LoadType.ReadMem & mis_s & ~MEM_ExceptValid;
  assign MEM_AdES = MEM_StoreType.DMWr & mis_s & ~MEM_ExceptValid;
  assign need_s   = (MEM_LoadType.ReadMem | MEM_StoreType.DMWr) & ~MEM_ExceptValid
                    & ~mis_s & ~MEM_Flush;

  store_lane_gen u_lane (
    .addr_lo_i (MEM_ALUOut[1:0]),
    .size_i    (data_size),
    .outb_i    (MEM_OutB),
    .wstrb_o   (lane_wstrb_s),
    .wdata_o   (data_wdata)
  );

  assign data_wstrb = MEM_StoreType.DMWr ? lane_wstrb_s : 4'b0000;

  assign data_req   = ((state_q == DACC_IDLE) & need_s) | (state_q == DACC_REQ);
  assign MEM_DMOut  = (state_q == DACC_DONE) ? rbuf_q : data_rdata;
  assign MEM_DStall = (need_s & ~(((state_q == DACC_WAIT) & data_data_ok) | (state_q == DACC_DONE)))
                      | (state_q == DACC_CANCEL);

  // Flush wins over Advance; a flushed outstanding request is drained in CANCEL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DACC_IDLE;
      rbuf_q  <= 32'h0000_0000;
    end else begin
      case (state_q)
        DACC_IDLE: begin
          if (need_s && data_addr_ok) state_q <= DACC_WAIT;
          else if (need_s)            state_q <= DACC_REQ;
          else                        state_q <= DACC_IDLE;
        end
        DACC_REQ: begin
          if (data_addr_ok)   state_q <= MEM_Flush ? DACC_CANCEL : DACC_WAIT;
          else if (MEM_Flush) state_q <= DACC_IDLE;
          else                state_q <= DACC_REQ;
        end
        DACC_WAIT: begin
          if (data_data_ok) begin
            if (MEM_Flush || MEM_Advance) begin
              state_q <= DACC_IDLE;
            end else begin
              state_q <= DACC_DONE;
              rbuf_q  <= data_rdata;
            end
          end else if (MEM_Flush) begin
            state_q <= DACC_CANCEL;
          end else begin
            state_q <= DACC_WAIT;
          end
        end
        DACC_DONE: begin
          if (MEM_Advance || MEM_Flush) state_q <= DACC_IDLE;
          else                          state_q <= DACC_DONE;
        end
        DACC_CANCEL: begin
          if (data_data_ok) state_q <= DACC_IDLE;
          else              state_q <= DACC_CANCEL;
        end
        default: state_q <= DACC_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_data_access.sv
// Randomized self-checking bench for mem_data_access; the bench acts as the
// data bus and predicts each cycle from transaction-level access rules.
module tb_mem_data_access;
  import mem_data_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] MEM_ALUOut, MEM_OutB;
  LoadType     MEM_LoadType;
  StoreType    MEM_StoreType;
  logic        MEM_ExceptValid, MEM_Flush, MEM_Advance;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata, MEM_DMOut;
  logic        MEM_DStall, MEM_AdEL, MEM_AdES;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_data_access dut (
    .clk(clk), .rst(rst), .MEM_ALUOut(MEM_ALUOut), .MEM_OutB(MEM_OutB),
    .MEM_LoadType(MEM_LoadType), .MEM_StoreType(MEM_StoreType),
    .MEM_ExceptValid(MEM_ExceptValid), .MEM_Flush(MEM_Flush), .MEM_Advance(MEM_Advance),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata), .MEM_DMOut(MEM_DMOut),
    .MEM_DStall(MEM_DStall), .MEM_AdEL(MEM_AdEL), .MEM_AdES(MEM_AdES)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    MEM_ALUOut = 32'h0; MEM_OutB = 32'h0;
    MEM_LoadType = 4'b0000; MEM_StoreType = 3'b000;
    MEM_ExceptValid = 1'b0; MEM_Flush = 1'b0; MEM_Advance = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
  endtask

  // op: 0 lb, 1 lh, 2 lw, 3 sb, 4 sh, 5 sw. aw = cycles before addr_ok,
  // dw = cycles from accept to data_ok, adv_d = cycles Advance is held low after data_ok.
  task automatic do_access(input int op, input logic sgn, input logic [31:0] addr,
                           input logic [31:0] outb, input logic exc, input int aw,
                           input int dw, input int adv_d, input logic [31:0] rword);
    int          nb;
    logic [1:0]  sz;
    logic        is_st, mis;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata, latched;
    nb    = (op % 3 == 0) ? 1 : ((op % 3 == 1) ? 2 : 4);
    sz    = 2'(op % 3);
    is_st = (op >= 3);
    mis   = (addr % nb) != 0;
    MEM_ALUOut = addr; MEM_OutB = outb; MEM_ExceptValid = exc;
    MEM_LoadType  = is_st ? 4'b0000 : {1'b1, sgn, sz};
    MEM_StoreType = is_st ? {1'b1, sz} : 3'b000;
    exp_strb = 4'b0000;
    for (int b = 0; b < 4; b++)
      if (is_st && b >= addr % 4 && b < (addr % 4) + nb) exp_strb[b] = 1'b1;
    exp_wdata = (nb == 1) ? outb[7:0] * 32'h0101_0101 :
                (nb == 2) ? outb[15:0] * 32'h0001_0001 : outb;
    if (exc || mis) begin
      MEM_Advance = 1'b1;
      #1;
      check_eq("adel", 32'(MEM_AdEL), 32'(!is_st && mis && !exc));
      check_eq("ades", 32'(MEM_AdES), 32'(is_st && mis && !exc));
      check_eq("noreq", 32'(data_req), 32'd0);
      check_eq("nostall", 32'(MEM_DStall), 32'd0);
      next_cycle();
    end else begin
      MEM_Advance = 1'b0;
      for (int i = 0; i <= aw; i++) begin
        data_addr_ok = (i == aw);
        #1;
        check_eq("req", 32'(data_req), 32'd1);
        check_eq("wr", 32'(data_wr), 32'(is_st));
        check_eq("size", 32'(data_size), 32'(sz));
        check_eq("addr", data_addr, addr);
        check_eq("wstrb", 32'(data_wstrb), 32'(exp_strb));
        if (is_st) check_eq("wdata", data_wdata, exp_wdata);
        check_eq("req_stall", 32'(MEM_DStall), 32'd1);
        next_cycle();
      end
      data_addr_ok = 1'b0;
      latched = rword;
      for (int j = 1; j <= dw; j++) begin
        data_data_ok = (j == dw);
        data_rdata   = (j == dw) ? rword : $urandom;
        MEM_Advance  = (j == dw) && (adv_d == 0);
        #1;
        check_eq("wait_req", 32'(data_req), 32'd0);
        check_eq("wait_stall", 32'(MEM_DStall), 32'((j == dw) ? 0 : 1));
        if (j == dw && !is_st) check_eq("dmout", MEM_DMOut, rword);
        next_cycle();
      end
      data_data_ok = 1'b0;
      for (int k = 1; k <= adv_d; k++) begin
        data_rdata  = $urandom;
        MEM_Advance = (k == adv_d);
        #1;
        check_eq("done_stall", 32'(MEM_DStall), 32'd0);
        check_eq("done_req", 32'(data_req), 32'd0);
        if (!is_st) check_eq("done_dmout", MEM_DMOut, latched);
        next_cycle();
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    data_rdata = 32'h5555_AAAA;
    #12;
    check_eq("rst_req", 32'(data_req), 32'd0);
    check_eq("rst_stall", 32'(MEM_DStall), 32'd0);
    check_eq("rst_dmout", MEM_DMOut, 32'h5555_AAAA);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    next_cycle();

    // Directed cases from the access rules.
    do_access(2, 1'b0, 32'h100, 32'h0, 1'b0, 0, 1, 0, 32'hDEAD_BEEF);
    do_access(3, 1'b0, 32'h103, 32'h1234_5678, 1'b0, 0, 1, 0, 32'h0);
    do_access(1, 1'b1, 32'h101, 32'h0, 1'b0, 0, 1, 0, 32'h0);
    do_access(1, 1'b1, 32'h101, 32'h0, 1'b1, 0, 1, 0, 32'h0);
    do_access(5, 1'b0, 32'h102, 32'hCAFE_0000, 1'b0, 0, 1, 0, 32'h0);
    do_access(2, 1'b0, 32'h300, 32'h0, 1'b0, 1, 2, 3, 32'h1357_9BDF);

    // Flush in WAIT, then a new lw waits in CANCEL for the orphaned response.
    MEM_LoadType = {1'b1, 1'b0, SIZE_W}; MEM_ALUOut = 32'h200; data_addr_ok = 1'b1;
    #1 check_eq("fl_req", 32'(data_req), 32'd1);
    next_cycle();
    data_addr_ok = 1'b0; MEM_Flush = 1'b1;
    #1 check_eq("fl_wait_req", 32'(data_req), 32'd0);
    check_eq("fl_wait_stall", 32'(MEM_DStall), 32'd0);
    next_cycle();
    MEM_Flush = 1'b0; MEM_ALUOut = 32'h204;
    for (int c = 0; c < 3; c++) begin
      data_data_ok = (c == 2); data_rdata = $urandom;
      #1 check_eq("cancel_req", 32'(data_req), 32'd0);
      check_eq("cancel_stall", 32'(MEM_DStall), 32'd1);
      next_cycle();
    end
    data_data_ok = 1'b0;
    do_access(2, 1'b0, 32'h204, 32'h0, 1'b0, 0, 1, 0, 32'h0BAD_F00D);

    // Flush in REQ without addr_ok drops the request.
    MEM_LoadType = {1'b1, 1'b0, SIZE_W}; MEM_ALUOut = 32'h208;
    #1 check_eq("rq_req", 32'(data_req), 32'd1);
    next_cycle();
    MEM_Flush = 1'b1;
    #1 check_eq("rq_fl_req", 32'(data_req), 32'd1);
    check_eq("rq_fl_stall", 32'(MEM_DStall), 32'd0);
    next_cycle();
    idle_inputs();
    #1 check_eq("rq_idle_req", 32'(data_req), 32'd0);
    check_eq("rq_idle_stall", 32'(MEM_DStall), 32'd0);
    next_cycle();

    // Reset while a request is outstanding.
    MEM_LoadType = {1'b1, 1'b0, SIZE_W}; MEM_ALUOut = 32'h400; data_addr_ok = 1'b1;
    next_cycle();
    idle_inputs();
    rst = 1'b1;
    #1 check_eq("mid_rst_req", 32'(data_req), 32'd0);
    check_eq("mid_rst_stall", 32'(MEM_DStall), 32'd0);
    next_cycle();
    rst = 1'b0;
    next_cycle();
    do_access(2, 1'b0, 32'h404, 32'h0, 1'b0, 0, 1, 2, 32'h2468_ACE0);

    for (int n = 0; n < 150; n++) begin
      int          op;
      logic [31:0] a;
      op = $urandom_range(0, 5);
      a  = {20'h0, 12'($urandom)};
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      do_access(op, 1'($urandom), a, $urandom, ($urandom_range(0, 9) == 0),
                $urandom_range(0, 2), $urandom_range(1, 3), $urandom_range(0, 2), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
